// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed 7-segment driver with frame-synchronous, tear-free display updates.
// Build option: define SEG7_LZB_EN to blank leading zero digits (digit 0 is never blanked).
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  // state | meaning
  // IDLE  | outputs dark, idx/cnt held at 0, waiting for ena
  // SCAN  | stepping through digit slots; active refreshed only at the frame boundary

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(DWELL_CYCLES + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] LIT_END  = CNT_W'(DWELL_CYCLES - BLANK_CYCLES);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [4*NUM_DIGITS-1:0] active_bcd_q;
  logic [NUM_DIGITS-1:0]   active_dp_q;
  logic [4*NUM_DIGITS-1:0] pend_bcd_q;
  logic [NUM_DIGITS-1:0]   pend_dp_q;
  logic                    pend_valid_q;
  logic [6:0]              seg_q;
  logic                    dp_q;
  logic [NUM_DIGITS-1:0]   digit_sel_q;
  logic                    frame_done_q;

  logic [3:0]              nib_d;
  logic                    dp_d;
  logic [6:0]              seg_d;
  logic [NUM_DIGITS-1:0]   sel_d;
  logic                    boundary_d;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  always_comb begin
    nib_d = 4'h0;
    dp_d  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_d = active_bcd_q[4*i +: 4];
        dp_d  = active_dp_q[i];
      end
    end
  end

`ifdef SEG7_LZB_EN
  logic [NUM_DIGITS-1:0] nz;
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  blank_d;

  // A digit is blanked when it and every digit above it are zero; invalid nibbles count as nonzero.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lzb
    assign nz[g] = |active_bcd_q[4*g +: 4];
    if (g == 0) begin : g_lsd
      assign lz_blank[g] = 1'b0;
    end else begin : g_upper
      assign lz_blank[g] = ~|nz[NUM_DIGITS-1:g];
    end
  end

  always_comb begin
    blank_d = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) blank_d = lz_blank[i];
    end
  end

  assign seg_d = blank_d ? 7'h00 : decode(nib_d);
`else
  assign seg_d = decode(nib_d);
`endif

  assign sel_d      = (cnt_q < LIT_END) ? (NUM_DIGITS'(1) << idx_q) : '0;
  assign boundary_d = (idx_q == IDX_LAST) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      active_bcd_q <= '0;
      active_dp_q  <= '0;
      pend_bcd_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      seg_q        <= 7'h00;
      dp_q         <= 1'b0;
      digit_sel_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      if (load) begin
        pend_bcd_q   <= bcd_in;
        pend_dp_q    <= dp_in;
        pend_valid_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          seg_q        <= 7'h00;
          dp_q         <= 1'b0;
          digit_sel_q  <= '0;
          frame_done_q <= 1'b0;
          idx_q        <= '0;
          cnt_q        <= '0;
          if (ena) begin
            state_q <= SCAN;
            if (pend_valid_q) begin
              active_bcd_q <= pend_bcd_q;
              active_dp_q  <= pend_dp_q;
            end
            // A load on the entry edge lands in pending and waits for the first boundary.
            pend_valid_q <= load;
          end
        end

        SCAN: begin
          if (!ena) begin
            state_q      <= IDLE;
            seg_q        <= 7'h00;
            dp_q         <= 1'b0;
            digit_sel_q  <= '0;
            frame_done_q <= 1'b0;
            idx_q        <= '0;
            cnt_q        <= '0;
          end else begin
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            digit_sel_q  <= sel_d;
            frame_done_q <= boundary_d;

            if (cnt_q == CNT_LAST) begin
              cnt_q <= '0;
              idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end

            if (boundary_d) begin
              if (load) begin
                active_bcd_q <= bcd_in;
                active_dp_q  <= dp_in;
              end else if (pend_valid_q) begin
                active_bcd_q <= pend_bcd_q;
                active_dp_q  <= pend_dp_q;
              end
              pend_valid_q <= 1'b0;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign digit_sel  = digit_sel_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (4 digits, 4-clock dwell, 1 blank clock, 16-clock frames).
// Expected outputs per frame position are queued from the intended display value and popped per clock.
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic        load;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  digit_sel;
  logic        frame_done;

  logic [12:0] obs;
  logic [12:0] exp_v;
  logic [12:0] sb[$];
  int          n_assert;
  int          n_fail;

  seg7_scan_driver #(
    .NUM_DIGITS  (4),
    .DWELL_CYCLES(4),
    .BLANK_CYCLES(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .load      (load),
    .bcd_in    (bcd_in),
    .dp_in     (dp_in),
    .seg       (seg),
    .dp        (dp),
    .digit_sel (digit_sel),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    case (n)
      4'd0: ref_seg = 7'h3F;
      4'd1: ref_seg = 7'h06;
      4'd2: ref_seg = 7'h5B;
      4'd3: ref_seg = 7'h4F;
      4'd4: ref_seg = 7'h66;
      4'd5: ref_seg = 7'h6D;
      4'd6: ref_seg = 7'h7D;
      4'd7: ref_seg = 7'h07;
      4'd8: ref_seg = 7'h7F;
      4'd9: ref_seg = 7'h6F;
      default: ref_seg = 7'h40;
    endcase
  endfunction

  // Queue {seg,dp,digit_sel,frame_done} for the first n positions of a frame showing v/d.
  task automatic push_frame(input logic [15:0] v, input logic [3:0] d, input int n);
    int         ix;
    int         c;
    logic [6:0] s;
    logic [3:0] sel;
    for (int p = 0; p < n; p++) begin
      ix = p / 4;
      c  = p % 4;
      s  = ref_seg(v[4*ix +: 4]);
`ifdef SEG7_LZB_EN
      if (ix > 0 && (v >> (4*ix)) == 16'h0000) s = 7'h00;
`endif
      sel = (c < 3) ? (4'b0001 << ix) : 4'b0000;
      sb.push_back({s, d[ix], sel, (p == 15)});
    end
  endtask

  task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] d);
    load = ld;
    if (ld) begin
      bcd_in = v;
      dp_in  = d;
    end
    @(posedge clk);
    #1;
    load = 1'b0;
    obs  = {seg, dp, digit_sel, frame_done};
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    obs = {seg, dp, digit_sel, frame_done};
    n_assert++;
    if (obs !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h want %h", obs, 13'h0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    ena = 1'b1;
    step(1'b0, 16'h0, 4'h0);
    n_assert++;
    if (obs !== 13'h0) begin
      n_fail++;
      $display("FAIL basic_entry got %h want %h", obs, 13'h0);
    end
    push_frame(16'h0000, 4'h0, 16);
    for (int p = 0; p < 16; p++) begin
      step(p == 2, 16'h1234, 4'h0);
      exp_v = sb.pop_front();
      n_assert++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL basic_frame0 p=%0d {seg,dp,sel,fd} got %h want %h", p, obs, exp_v);
      end
    end
    push_frame(16'h1234, 4'h0, 16);
    for (int p = 0; p < 16; p++) begin
      step(1'b0, 16'h0, 4'h0);
      exp_v = sb.pop_front();
      n_assert++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL basic_frame1 p=%0d {seg,dp,sel,fd} got %h want %h", p, obs, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    push_frame(16'h1234, 4'h0, 16);
    for (int p = 0; p < 16; p++) begin
      if (p == 3) step(1'b1, 16'h1111, 4'h0);
      else        step(p == 9, 16'h2222, 4'h0);
      exp_v = sb.pop_front();
      n_assert++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL b2b_hold p=%0d {seg,dp,sel,fd} got %h want %h", p, obs, exp_v);
      end
    end
    push_frame(16'h2222, 4'h0, 16);
    for (int p = 0; p < 16; p++) begin
      step(p == 15, 16'h9876, 4'h0);
      exp_v = sb.pop_front();
      n_assert++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL b2b_latest p=%0d {seg,dp,sel,fd} got %h want %h", p, obs, exp_v);
      end
    end
  endtask

  task automatic test_boundary_load();
    push_frame(16'h9876, 4'h0, 16);
    for (int p = 0; p < 16; p++) begin
      step(p == 5, 16'h00AF, 4'b0010);
      exp_v = sb.pop_front();
      n_assert++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL boundary_direct p=%0d {seg,dp,sel,fd} got %h want %h", p, obs, exp_v);
      end
    end
  endtask

  task automatic test_invalid_dp();
    push_frame(16'h00AF, 4'b0010, 16);
    for (int p = 0; p < 16; p++) begin
      step(1'b0, 16'h0, 4'h0);
      exp_v = sb.pop_front();
      n_assert++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL invalid_dp p=%0d {seg,dp,sel,fd} got %h want %h", p, obs, exp_v);
      end
    end
  endtask

  task automatic test_ena_drop();
    push_frame(16'h00AF, 4'b0010, 6);
    for (int p = 0; p < 6; p++) begin
      step(1'b0, 16'h0, 4'h0);
      exp_v = sb.pop_front();
      n_assert++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL ena_pre p=%0d {seg,dp,sel,fd} got %h want %h", p, obs, exp_v);
      end
    end
    ena = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(k == 2, 16'h0050, 4'h0);
      n_assert++;
      if (obs !== 13'h0) begin
        n_fail++;
        $display("FAIL ena_dark k=%0d got %h want %h", k, obs, 13'h0);
      end
    end
    ena = 1'b1;
    step(1'b0, 16'h0, 4'h0);
    n_assert++;
    if (obs !== 13'h0) begin
      n_fail++;
      $display("FAIL ena_reentry got %h want %h", obs, 13'h0);
    end
    push_frame(16'h0050, 4'h0, 16);
    for (int p = 0; p < 16; p++) begin
      step(p == 15, 16'h0000, 4'h0);
      exp_v = sb.pop_front();
      n_assert++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL ena_restart p=%0d {seg,dp,sel,fd} got %h want %h", p, obs, exp_v);
      end
    end
    push_frame(16'h0000, 4'h0, 16);
    for (int p = 0; p < 16; p++) begin
      step(1'b0, 16'h0, 4'h0);
      exp_v = sb.pop_front();
      n_assert++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL zero_value p=%0d {seg,dp,sel,fd} got %h want %h", p, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    push_frame(16'h0000, 4'h0, 7);
    for (int p = 0; p < 7; p++) begin
      step(p == 4, 16'h4444, 4'hF);
      exp_v = sb.pop_front();
      n_assert++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL rstmid_pre p=%0d {seg,dp,sel,fd} got %h want %h", p, obs, exp_v);
      end
    end
    rst_n = 1'b0;
    #2;
    obs = {seg, dp, digit_sel, frame_done};
    n_assert++;
    if (obs !== 13'h0) begin
      n_fail++;
      $display("FAIL rstmid_async got %h want %h", obs, 13'h0);
    end
    step(1'b0, 16'h0, 4'h0);
    step(1'b0, 16'h0, 4'h0);
    rst_n = 1'b1;
    step(1'b0, 16'h0, 4'h0);
    n_assert++;
    if (obs !== 13'h0) begin
      n_fail++;
      $display("FAIL rstmid_entry got %h want %h", obs, 13'h0);
    end
    push_frame(16'h0000, 4'h0, 16);
    for (int p = 0; p < 16; p++) begin
      step(1'b0, 16'h0, 4'h0);
      exp_v = sb.pop_front();
      n_assert++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL rstmid_nocommit p=%0d {seg,dp,sel,fd} got %h want %h", p, obs, exp_v);
      end
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    ena      = 1'b0;
    load     = 1'b0;
    bcd_in   = 16'h0;
    dp_in    = 4'h0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_boundary_load();
    test_invalid_dp();
    test_ena_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
